// File: rtl/alu_exec_unit_if.sv
// Bus bundle for the ALU execute stage: stage-advance, operation select,
// operands, branch inputs, the combinational decoded operation and the
// registered results. The driver of the stage uses "master"; the ALU uses
// "slave".
interface alu_exec_unit_if #(
  parameter int DATA_W = 16
);
  logic              en;
  logic [3:0]        funct;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] se_offset;
  logic [3:0]        operation;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] remainder;
  logic              o;
  logic              zero;
  logic [DATA_W-1:0] branch_addr;

  modport master (
    output en, funct, alu_op, op1, op2, pc_in, se_offset,
    input  operation, result, remainder, o, zero, branch_addr
  );

  modport slave (
    input  en, funct, alu_op, op1, op2, pc_in, se_offset,
    output operation, result, remainder, o, zero, branch_addr
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: decodes the operation, evaluates ADD/SUB/MUL/DIV,
// logical shifts and rotates, PASS and NOP, computes the branch target,
// and registers every result with one cycle of latency when en is high.
// Registers clear asynchronously while reset (active low) is asserted.
module alu_exec_unit #(
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  alu_bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_ROL  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;
  localparam logic [3:0] OP_NOP  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  localparam int MSB = DATA_W - 1;

  logic [3:0]               w_operation;
  logic [DATA_W-1:0]        w_op1;
  logic [DATA_W-1:0]        w_op2;
  logic [DATA_W-1:0]        w_sum;
  logic [DATA_W-1:0]        w_diff;
  logic                     w_add_ovf;
  logic                     w_sub_ovf;
  logic [2*DATA_W-1:0]      w_op1_ext;
  logic [2*DATA_W-1:0]      w_op2_ext;
  logic signed [2*DATA_W-1:0] w_product;
  logic [DATA_W:0]          w_prod_top;
  logic                     w_mul_ovf;
  logic                     w_div_zero;
  logic                     w_div_ovf;
  logic [DATA_W-1:0]        w_divisor;
  logic signed [DATA_W-1:0] w_quot;
  logic signed [DATA_W-1:0] w_rem;
  logic [3:0]               w_amt;
  logic [2*DATA_W-1:0]      w_rol_wide;
  logic [2*DATA_W-1:0]      w_ror_wide;
  logic [DATA_W-1:0]        w_result;
  logic [DATA_W-1:0]        w_remainder;
  logic                     w_ovf;
  logic                     w_zero;
  logic [DATA_W-1:0]        w_branch;
  logic                     w_unused_bits;

  logic [DATA_W-1:0]        r_result;
  logic [DATA_W-1:0]        r_remainder;
  logic                     r_o;
  logic                     r_zero;
  logic [DATA_W-1:0]        r_branch_addr;

  assign w_op1 = alu_bus.op1;
  assign w_op2 = alu_bus.op2;

  // Decode the ALU operation from the control class and the R-type funct.
  always_comb begin
    w_operation = OP_NOP;
    case (alu_bus.alu_op)
      2'b00: begin
        case (alu_bus.funct)
          OP_ADD, OP_SUB, OP_MUL, OP_DIV,
          OP_SLL, OP_SRL, OP_ROL, OP_ROR: w_operation = alu_bus.funct;
          default:                        w_operation = OP_NOP;
        endcase
      end
      2'b01:   w_operation = OP_ADD;
      2'b10:   w_operation = OP_SUB;
      2'b11:   w_operation = OP_PASS;
      default: w_operation = OP_NOP;
    endcase
  end

  assign alu_bus.operation = w_operation;

  // Add/subtract with signed overflow: operand signs vs. result sign.
  assign w_sum     = w_op1 + w_op2;
  assign w_diff    = w_op1 - w_op2;
  assign w_add_ovf = (w_op1[MSB] == w_op2[MSB]) && (w_sum[MSB]  != w_op1[MSB]);
  assign w_sub_ovf = (w_op1[MSB] != w_op2[MSB]) && (w_diff[MSB] != w_op1[MSB]);

  // Full-width signed product; it fits the narrow range only when the top
  // DATA_W+1 bits are a pure sign extension.
  assign w_op1_ext  = {{DATA_W{w_op1[MSB]}}, w_op1};
  assign w_op2_ext  = {{DATA_W{w_op2[MSB]}}, w_op2};
  assign w_product  = $signed(w_op1_ext) * $signed(w_op2_ext);
  assign w_prod_top = w_product[2*DATA_W-1:DATA_W-1];
  assign w_mul_ovf  = !((&w_prod_top) || !(|w_prod_top));

  // Divide-by-zero and most-negative / -1 are handled explicitly, so the
  // divider only ever sees a safe divisor.
  assign w_div_zero = (w_op2 == {DATA_W{1'b0}});
  assign w_div_ovf  = (w_op1 == {1'b1, {(DATA_W-1){1'b0}}}) && (w_op2 == {DATA_W{1'b1}});
  assign w_divisor  = (w_div_zero || w_div_ovf) ? {{(DATA_W-1){1'b0}}, 1'b1} : w_op2;
  assign w_quot     = $signed(w_op1) / $signed(w_divisor);
  assign w_rem      = $signed(w_op1) % $signed(w_divisor);

  // Rotates via a doubled operand: the wrapped bits land in the kept half,
  // and an amount of 0 naturally returns op1.
  assign w_amt      = w_op2[3:0];
  assign w_rol_wide = {w_op1, w_op1} << w_amt;
  assign w_ror_wide = {w_op1, w_op1} >> w_amt;

  // Branch target: halfword offset scaled to bytes, wrapping at 2^DATA_W.
  assign w_branch = alu_bus.pc_in + {alu_bus.se_offset[MSB-1:0], 1'b0};

  // Bits that are structurally discarded (offset sign past the shift, the
  // unused halves of the rotate helpers).
  assign w_unused_bits = ^{alu_bus.se_offset[MSB], w_rol_wide[DATA_W-1:0],
                           w_ror_wide[2*DATA_W-1:DATA_W]};

  // Select the primary/secondary results and the exception flag.
  always_comb begin
    w_result    = {DATA_W{1'b0}};
    w_remainder = {DATA_W{1'b0}};
    w_ovf       = 1'b0;
    case (w_operation)
      OP_ADD: begin
        w_result = w_sum;
        w_ovf    = w_add_ovf;
      end
      OP_SUB: begin
        w_result = w_diff;
        w_ovf    = w_sub_ovf;
      end
      OP_MUL: begin
        w_result    = w_product[DATA_W-1:0];
        w_remainder = w_product[2*DATA_W-1:DATA_W];
        w_ovf       = w_mul_ovf;
      end
      OP_DIV: begin
        if (w_div_zero) begin
          w_result    = {DATA_W{1'b1}};
          w_remainder = w_op1;
          w_ovf       = 1'b1;
        end else if (w_div_ovf) begin
          w_result    = w_op1;
          w_remainder = {DATA_W{1'b0}};
          w_ovf       = 1'b1;
        end else begin
          w_result    = w_quot;
          w_remainder = w_rem;
          w_ovf       = 1'b0;
        end
      end
      OP_SLL:  w_result = w_op1 << w_amt;
      OP_SRL:  w_result = w_op1 >> w_amt;
      OP_ROL:  w_result = w_rol_wide[2*DATA_W-1:DATA_W];
      OP_ROR:  w_result = w_ror_wide[DATA_W-1:0];
      OP_PASS: w_result = w_op2;
      OP_NOP:  w_result = {DATA_W{1'b0}};
      default: w_result = {DATA_W{1'b0}};
    endcase
  end

  assign w_zero = (w_result == {DATA_W{1'b0}});

  // Output stage: async clear on reset, capture on en, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result      <= {DATA_W{1'b0}};
      r_remainder   <= {DATA_W{1'b0}};
      r_o           <= 1'b0;
      r_zero        <= 1'b0;
      r_branch_addr <= {DATA_W{1'b0}};
    end else if (alu_bus.en) begin
      r_result      <= w_result;
      r_remainder   <= w_remainder;
      r_o           <= w_ovf;
      r_zero        <= w_zero;
      r_branch_addr <= w_branch;
    end
  end

  assign alu_bus.result      = r_result;
  assign alu_bus.remainder   = r_remainder;
  assign alu_bus.o           = r_o;
  assign alu_bus.zero        = r_zero;
  assign alu_bus.branch_addr = r_branch_addr;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + randomized bench for alu_exec_unit. Expected results are pushed
// to a scoreboard queue when stimulus is driven and popped one edge later.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.DATA_W(16)) alu_bus ();

  alu_exec_unit #(.DATA_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .alu_bus (alu_bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic [15:0] rem;
    logic        o;
    logic        z;
    logic [15:0] br;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] model_dec(input logic [1:0] aop, input logic [3:0] f);
    logic [3:0] r;
    r = 4'hE;
    if (aop == 2'b01) r = 4'h0;
    else if (aop == 2'b10) r = 4'h1;
    else if (aop == 2'b11) r = 4'hF;
    else if (f inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) r = f;
    return r;
  endfunction

  task automatic model_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic [15:0] rem, output logic o);
    int sa, sbv, t;
    logic [15:0] r;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    res = 16'h0000;
    rem = 16'h0000;
    o   = 1'b0;
    t   = 0;
    case (op)
      4'h0: begin t = sa + sbv; res = t[15:0]; o = (t > 32767) || (t < -32768); end
      4'h1: begin t = sa - sbv; res = t[15:0]; o = (t > 32767) || (t < -32768); end
      4'h4: begin
        t = sa * sbv; res = t[15:0]; rem = t[31:16];
        o = (t > 32767) || (t < -32768);
      end
      4'h5: begin
        if (sbv == 0) begin
          res = 16'hFFFF; rem = a; o = 1'b1;
        end else if (sa == -32768 && sbv == -1) begin
          res = 16'h8000; rem = 16'h0000; o = 1'b1;
        end else begin
          t = sa / sbv; res = t[15:0];
          t = sa % sbv; rem = t[15:0];
        end
      end
      4'h8: res = a << b[3:0];
      4'h9: res = a >> b[3:0];
      4'hA: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) r = {r[14:0], r[15]};
        res = r;
      end
      4'hB: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) r = {r[0], r[15:1]};
        res = r;
      end
      4'hF: res = b;
      default: res = 16'h0000;
    endcase
  endtask

  function automatic logic [15:0] model_br(input logic [15:0] pc, input logic [15:0] off);
    int t;
    t = int'(pc) + 2 * int'(off);
    return t[15:0];
  endfunction

  // Drive one operation at the falling edge and check the combinational decode.
  task automatic send(input logic [1:0] aop, input logic [3:0] f, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] pc, input logic [15:0] off,
                      input logic en_v, input string tag);
    @(negedge clk);
    alu_bus.en        = en_v;
    alu_bus.alu_op    = aop;
    alu_bus.funct     = f;
    alu_bus.op1       = a;
    alu_bus.op2       = b;
    alu_bus.pc_in     = pc;
    alu_bus.se_offset = off;
    #1;
    chk({tag, "_operation"}, {12'h000, alu_bus.operation}, {12'h000, model_dec(aop, f)});
  endtask

  task automatic push_exp(input string tag, input logic [15:0] res, input logic [15:0] rem,
                          input logic o, input logic z, input logic [15:0] br);
    exp_t e;
    e.tag = tag; e.res = res; e.rem = rem; e.o = o; e.z = z; e.br = br;
    sb_q.push_back(e);
  endtask

  task automatic push_model(input string tag);
    logic [15:0] res, rem;
    logic        o;
    model_alu(model_dec(alu_bus.alu_op, alu_bus.funct), alu_bus.op1, alu_bus.op2, res, rem, o);
    push_exp(tag, res, rem, o, (res == 16'h0000), model_br(alu_bus.pc_in, alu_bus.se_offset));
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, "_result"},      alu_bus.result,               e.res);
    chk({tag, "_remainder"},   alu_bus.remainder,            e.rem);
    chk({tag, "_o"},           {15'h0000, alu_bus.o},        {15'h0000, e.o});
    chk({tag, "_zero"},        {15'h0000, alu_bus.zero},     {15'h0000, e.z});
    chk({tag, "_branch_addr"}, alu_bus.branch_addr,          e.br);
  endtask

  // Wait for the capture edge and compare the DUT against the queue head.
  task automatic take();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 16'h0001, 16'h0000);
    end else begin
      e = sb_q.pop_front();
      chk_outputs(e.tag, e);
      last_exp = e;
    end
  endtask

  task automatic step_k(input logic [1:0] aop, input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] pc, input logic [15:0] off,
                        input logic [15:0] res, input logic [15:0] rem, input logic o,
                        input logic z, input logic [15:0] br, input string tag);
    send(aop, f, a, b, pc, off, 1'b1, tag);
    push_exp(tag, res, rem, o, z, br);
    take();
  endtask

  exp_t zero_exp;

  initial begin
    zero_exp.tag = "reset"; zero_exp.res = 16'h0000; zero_exp.rem = 16'h0000;
    zero_exp.o = 1'b0; zero_exp.z = 1'b0; zero_exp.br = 16'h0000;

    // Reset asserted between edges with random inputs: clears without a clock.
    reset             = 1'b1;
    alu_bus.en        = 1'b1;
    alu_bus.alu_op    = 2'($urandom);
    alu_bus.funct     = 4'($urandom);
    alu_bus.op1       = 16'($urandom);
    alu_bus.op2       = 16'($urandom);
    alu_bus.pc_in     = 16'($urandom);
    alu_bus.se_offset = 16'($urandom);
    #2 reset = 1'b0;
    #1 chk_outputs("reset_async", zero_exp);
    // Reset wins over en across several edges.
    repeat (2) @(posedge clk);
    #1 chk_outputs("reset_over_en", zero_exp);
    @(negedge clk);
    alu_bus.en = 1'b0;
    reset      = 1'b1;

    // First capture after release.
    step_k(2'b01, 4'h0, 16'h0003, 16'h0004, 16'h0000, 16'h0000,
           16'h0007, 16'h0000, 1'b0, 1'b0, 16'h0000, "add_first");

    // Directed arithmetic and boundary cases.
    step_k(2'b00, 4'h0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000,
           16'h8000, 16'h0000, 1'b1, 1'b0, 16'h0000, "add_ovf");
    step_k(2'b00, 4'h1, 16'h8000, 16'h0001, 16'h0000, 16'h0000,
           16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h0000, "sub_ovf");
    step_k(2'b10, 4'h7, 16'h0005, 16'h0007, 16'h0000, 16'h0000,
           16'hFFFE, 16'h0000, 1'b0, 1'b0, 16'h0000, "sub_class");
    step_k(2'b00, 4'h4, 16'h0100, 16'h0100, 16'h0000, 16'h0000,
           16'h0000, 16'h0001, 1'b1, 1'b1, 16'h0000, "mul_ovf");
    step_k(2'b00, 4'h4, 16'hFFFE, 16'h0003, 16'h0000, 16'h0000,
           16'hFFFA, 16'hFFFF, 1'b0, 1'b0, 16'h0000, "mul_neg");
    step_k(2'b00, 4'h5, 16'h0007, 16'h0002, 16'h0000, 16'h0000,
           16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0000, "div_pos");
    step_k(2'b00, 4'h5, 16'hFFF9, 16'h0002, 16'h0000, 16'h0000,
           16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 16'h0000, "div_neg");
    step_k(2'b00, 4'h5, 16'h0005, 16'h0000, 16'h0000, 16'h0000,
           16'hFFFF, 16'h0005, 1'b1, 1'b0, 16'h0000, "div_zero");
    step_k(2'b00, 4'h5, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000,
           16'h8000, 16'h0000, 1'b1, 1'b0, 16'h0000, "div_min");
    step_k(2'b00, 4'h8, 16'h8001, 16'h0001, 16'h0000, 16'h0000,
           16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0000, "sll");
    step_k(2'b00, 4'h9, 16'h8001, 16'h0001, 16'h0000, 16'h0000,
           16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, "srl");
    step_k(2'b00, 4'hA, 16'h8001, 16'h0001, 16'h0000, 16'h0000,
           16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, "rol");
    step_k(2'b00, 4'hB, 16'h8001, 16'h0001, 16'h0000, 16'h0000,
           16'hC000, 16'h0000, 1'b0, 1'b0, 16'h0000, "ror");
    step_k(2'b00, 4'hA, 16'h8001, 16'h0010, 16'h0000, 16'h0000,
           16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0000, "rol_amt0");
    step_k(2'b11, 4'h3, 16'h5555, 16'h1234, 16'h0000, 16'h0000,
           16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, "pass");
    step_k(2'b01, 4'h0, 16'h0000, 16'h0000, 16'h0010, 16'hFFFE,
           16'h0000, 16'h0000, 1'b0, 1'b1, 16'h000C, "branch_back");
    step_k(2'b01, 4'h0, 16'h0001, 16'h0001, 16'hFFFE, 16'h0002,
           16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0002, "branch_wrap");
    step_k(2'b00, 4'h6, 16'h1234, 16'h5678, 16'h0000, 16'h0000,
           16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, "nop_funct6");
    chk("nop_operation_value", {12'h000, alu_bus.operation}, 16'h000E);

    // Make the held state non-trivial, then hold en low while inputs change.
    step_k(2'b01, 4'h0, 16'h1111, 16'h2222, 16'h0100, 16'h0008,
           16'h3333, 16'h0000, 1'b0, 1'b0, 16'h0110, "pre_hold");
    for (int i = 0; i < 3; i++) begin
      send(2'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 1'b0, "hold");
      @(posedge clk);
      #1 chk_outputs("hold", last_exp);
    end

    // Reset during an in-flight operation discards it.
    send(2'b01, 4'h0, 16'h0101, 16'h0202, 16'h0300, 16'h0004, 1'b1, "inflight");
    #1 reset = 1'b0;
    #1 chk_outputs("reset_midstream", zero_exp);
    @(posedge clk);
    #1 chk_outputs("reset_midstream_edge", zero_exp);
    @(negedge clk);
    alu_bus.en = 1'b0;
    reset      = 1'b1;

    // Randomized back-to-back operations against the bench model.
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 1'b1, "rand");
      push_model("rand");
      take();
    end

    chk("scoreboard_drained", 16'(sb_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
